// File: rtl/cache_arbiter_pkg.sv
// Shared types for the instruction/data cache arbiter: FSM states and
// the record of which side was granted most recently.
package arbiter_types;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } stateT;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grantT;

endpackage

// File: rtl/cache_arbiter.sv
// Arbiter between an instruction cache and a data cache sharing one
// lower-level memory port. One transaction at a time; ties are broken
// round-robin using the side granted last.
module cache_arbiter
   import arbiter_types::*;
#(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              icache_read,
   input  logic [ADDR_W-1:0] icache_addr,
   output logic [LINE_W-1:0] icache_rdata,
   output logic              icache_resp,
   input  logic              dcache_read,
   input  logic              dcache_write,
   input  logic [ADDR_W-1:0] dcache_addr,
   input  logic [LINE_W-1:0] dcache_wdata,
   output logic [LINE_W-1:0] dcache_rdata,
   output logic              dcache_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   stateT r_state;
   stateT w_nextState;
   grantT r_lastGrant;
   logic  w_dReq;

   assign w_dReq = dcache_read | dcache_write;

   // Both sides see the memory line directly; only their resp qualifies it.
   assign icache_rdata = mem_rdata;
   assign dcache_rdata = mem_rdata;

   // State register plus the round-robin memory, captured when a grant is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_lastGrant <= GRANT_D;
      end else begin
         r_state <= w_nextState;
         if (r_state == IDLE && w_nextState == SERVE_I) begin
            r_lastGrant <= GRANT_I;
         end else if (r_state == IDLE && w_nextState == SERVE_D) begin
            r_lastGrant <= GRANT_D;
         end
      end
   end

   // Next-state: grant from IDLE, hold while serving until memory responds.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (icache_read && w_dReq) begin
               w_nextState = (r_lastGrant == GRANT_D) ? SERVE_I : SERVE_D;
            end else if (icache_read) begin
               w_nextState = SERVE_I;
            end else if (w_dReq) begin
               w_nextState = SERVE_D;
            end
         end
         SERVE_I: begin
            if (mem_resp) begin
               w_nextState = IDLE;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Memory strobes and completion pulses; everything is silenced while reset is held.
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      icache_resp = 1'b0;
      dcache_resp = 1'b0;
      if (!rst) begin
         case (r_state)
            SERVE_I: begin
               mem_read    = 1'b1;
               mem_addr    = icache_addr;
               icache_resp = mem_resp;
            end
            SERVE_D: begin
               mem_read    = dcache_read & ~dcache_write;
               mem_write   = dcache_write;
               mem_addr    = dcache_addr;
               mem_wdata   = dcache_wdata;
               dcache_resp = mem_resp;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes the expected
// completion, a negedge monitor pops and checks each resp pulse.
module tb_cache_arbiter;

   localparam int ADDR_W = 16;
   localparam int LINE_W = 256;

   typedef struct {
      logic [1:0]        respBits;
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic [LINE_W-1:0] rdata;
   } expT;

   logic              clk;
   logic              rst;
   logic              icache_read;
   logic [ADDR_W-1:0] icache_addr;
   logic [LINE_W-1:0] icache_rdata;
   logic              icache_resp;
   logic              dcache_read;
   logic              dcache_write;
   logic [ADDR_W-1:0] dcache_addr;
   logic [LINE_W-1:0] dcache_wdata;
   logic [LINE_W-1:0] dcache_rdata;
   logic              dcache_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;

   int  checks   = 0;
   int  failures = 0;
   expT expQ[$];

   cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .icache_read (icache_read),
      .icache_addr (icache_addr),
      .icache_rdata(icache_rdata),
      .icache_resp (icache_resp),
      .dcache_read (dcache_read),
      .dcache_write(dcache_write),
      .dcache_addr (dcache_addr),
      .dcache_wdata(dcache_wdata),
      .dcache_rdata(dcache_rdata),
      .dcache_resp (dcache_resp),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void checkOutput(input string name, input logic [LINE_W-1:0] act,
                                       input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Monitor: every completion pulse must match the oldest expected transaction.
   always @(negedge clk) begin
      if (icache_resp === 1'b1 || dcache_resp === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL stray_resp: got i=%0b d=%0b expected none", icache_resp, dcache_resp);
         end else begin
            expT e;
            e = expQ.pop_front();
            checkOutput("resp_side", LINE_W'({icache_resp, dcache_resp}), LINE_W'(e.respBits));
            checkOutput("resp_rdata", e.respBits[1] ? icache_rdata : dcache_rdata, e.rdata);
            checkOutput("resp_mem_read", LINE_W'(mem_read), LINE_W'(e.rd));
            checkOutput("resp_mem_write", LINE_W'(mem_write), LINE_W'(e.wr));
            checkOutput("resp_mem_addr", LINE_W'(mem_addr), LINE_W'(e.addr));
         end
      end
   end

   function automatic expT mkExp(input logic isI, input logic rd, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                                 input logic [LINE_W-1:0] rdata);
      expT e;
      e.respBits = isI ? 2'b10 : 2'b01;
      e.rd       = rd;
      e.wr       = wr;
      e.addr     = addr;
      e.wdata    = wdata;
      e.rdata    = rdata;
      return e;
   endfunction

   task automatic checkQuiet(input string name);
      checkOutput(name, LINE_W'({mem_read, mem_write, icache_resp, dcache_resp}), '0);
   endtask

   task automatic applyStimulus(input string name);
      $display("[TB] %s", name);
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk); #1;
      checkQuiet("during_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      checkQuiet("after_reset");
   endtask

   // Wait for the arbiter to raise a memory strobe, then hold it for k cycles,
   // answering with mem_resp in the k-th. Strobes are checked every cycle.
   task automatic serveMem(input int k, input expT e, input bit dropI);
      int  waitCnt;
      bit  got;
      waitCnt = 0;
      got     = 1'b0;
      while (!got && waitCnt < 20) begin
         @(posedge clk); #1;
         if (mem_read === 1'b1 || mem_write === 1'b1) got = 1'b1;
         else waitCnt++;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("[TB] FAIL strobe_timeout: got no strobe expected one within 20 cycles");
         return;
      end
      if (dropI) icache_read = 1'b0;
      for (int c = 1; c <= k; c++) begin
         checkOutput("strobe_read", LINE_W'(mem_read), LINE_W'(e.rd));
         checkOutput("strobe_write", LINE_W'(mem_write), LINE_W'(e.wr));
         checkOutput("strobe_addr", LINE_W'(mem_addr), LINE_W'(e.addr));
         if (e.wr) checkOutput("strobe_wdata", mem_wdata, e.wdata);
         if (c == k) begin
            mem_rdata = e.rdata;
            mem_resp  = 1'b1;
         end
         @(posedge clk); #1;
      end
      mem_resp  = 1'b0;
      mem_rdata = ~e.rdata;
      checkQuiet("idle_after_txn");
   endtask

   // Directed test sequence.
   initial begin
      logic [LINE_W-1:0] pat;
      logic [LINE_W-1:0] a5;
      rst          = 1'b1;
      icache_read  = 1'b0;
      icache_addr  = '0;
      dcache_read  = 1'b0;
      dcache_write = 1'b0;
      dcache_addr  = '0;
      dcache_wdata = '0;
      mem_rdata    = '0;
      mem_resp     = 1'b0;
      a5           = {32{8'hA5}};

      applyStimulus("reset and passthrough");
      doReset();
      pat       = {8{32'hDEAD_BEEF}};
      mem_rdata = pat;
      #1;
      checkOutput("icache_rdata_pass", icache_rdata, pat);
      checkOutput("dcache_rdata_pass", dcache_rdata, pat);

      applyStimulus("icache read 0x1200, three cycle memory");
      icache_read = 1'b1;
      icache_addr = 16'h1200;
      expQ.push_back(mkExp(1'b1, 1'b1, 1'b0, 16'h1200, '0, {8{32'h1111_2222}}));
      serveMem(3, mkExp(1'b1, 1'b1, 1'b0, 16'h1200, '0, {8{32'h1111_2222}}), 1'b0);
      icache_read = 1'b0;

      applyStimulus("icache drops request mid-transaction");
      icache_read = 1'b1;
      icache_addr = 16'h0ABC;
      expQ.push_back(mkExp(1'b1, 1'b1, 1'b0, 16'h0ABC, '0, {8{32'h3333_4444}}));
      serveMem(2, mkExp(1'b1, 1'b1, 1'b0, 16'h0ABC, '0, {8{32'h3333_4444}}), 1'b1);

      applyStimulus("simultaneous requests after reset");
      doReset();
      icache_read = 1'b1;
      icache_addr = 16'h0100;
      dcache_read = 1'b1;
      dcache_addr = 16'h0200;
      expQ.push_back(mkExp(1'b1, 1'b1, 1'b0, 16'h0100, '0, {8{32'h0000_0101}}));
      serveMem(2, mkExp(1'b1, 1'b1, 1'b0, 16'h0100, '0, {8{32'h0000_0101}}), 1'b0);
      icache_read = 1'b0;
      expQ.push_back(mkExp(1'b0, 1'b1, 1'b0, 16'h0200, '0, {8{32'h0000_0202}}));
      serveMem(2, mkExp(1'b0, 1'b1, 1'b0, 16'h0200, '0, {8{32'h0000_0202}}), 1'b0);
      dcache_read = 1'b0;

      applyStimulus("continuous requests alternate I,D,I,D,I,D");
      icache_read = 1'b1;
      icache_addr = 16'h0C00;
      dcache_read = 1'b1;
      dcache_addr = 16'h0D00;
      for (int t = 0; t < 6; t++) begin
         expT e;
         if (t % 2 == 0) e = mkExp(1'b1, 1'b1, 1'b0, 16'h0C00, '0, {8{32'h5000_0000 + 32'(t)}});
         else            e = mkExp(1'b0, 1'b1, 1'b0, 16'h0D00, '0, {8{32'h5000_0000 + 32'(t)}});
         expQ.push_back(e);
         serveMem(1 + (t % 3), e, 1'b0);
      end
      icache_read = 1'b0;
      dcache_read = 1'b0;

      applyStimulus("dcache write-back 0x3400");
      dcache_write = 1'b1;
      dcache_addr  = 16'h3400;
      dcache_wdata = a5;
      expQ.push_back(mkExp(1'b0, 1'b0, 1'b1, 16'h3400, a5, {8{32'h7777_7777}}));
      serveMem(3, mkExp(1'b0, 1'b0, 1'b1, 16'h3400, a5, {8{32'h7777_7777}}), 1'b0);

      applyStimulus("dcache read and write together, write wins");
      dcache_read  = 1'b1;
      dcache_addr  = 16'h3480;
      dcache_wdata = {8{32'h0F0F_1234}};
      expQ.push_back(mkExp(1'b0, 1'b0, 1'b1, 16'h3480, {8{32'h0F0F_1234}}, {8{32'h8888_0000}}));
      serveMem(2, mkExp(1'b0, 1'b0, 1'b1, 16'h3480, {8{32'h0F0F_1234}}, {8{32'h8888_0000}}), 1'b0);
      dcache_write = 1'b0;
      dcache_read  = 1'b0;

      applyStimulus("reset during SERVE_D, stray mem_resp in IDLE");
      dcache_read = 1'b1;
      dcache_addr = 16'h5000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("serve_d_before_reset", LINE_W'(mem_read), LINE_W'(1'b1));
      rst = 1'b1;
      #1;
      checkQuiet("serve_d_in_reset");
      @(posedge clk); #1;
      rst         = 1'b0;
      dcache_read = 1'b0;
      checkQuiet("idle_after_abort");
      mem_resp = 1'b1;
      @(posedge clk); #1;
      checkQuiet("stray_resp_1");
      @(posedge clk); #1;
      checkQuiet("stray_resp_2");
      mem_resp = 1'b0;

      applyStimulus("tie after abort goes to icache first");
      icache_read = 1'b1;
      icache_addr = 16'h0E00;
      dcache_read = 1'b1;
      dcache_addr = 16'h0F00;
      expQ.push_back(mkExp(1'b1, 1'b1, 1'b0, 16'h0E00, '0, {8{32'h9999_0001}}));
      serveMem(1, mkExp(1'b1, 1'b1, 1'b0, 16'h0E00, '0, {8{32'h9999_0001}}), 1'b0);
      icache_read = 1'b0;
      expQ.push_back(mkExp(1'b0, 1'b1, 1'b0, 16'h0F00, '0, {8{32'h9999_0002}}));
      serveMem(1, mkExp(1'b0, 1'b1, 1'b0, 16'h0F00, '0, {8{32'h9999_0002}}), 1'b0);
      dcache_read = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", LINE_W'(expQ.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "[TB] timeout");
   end

endmodule
